demux1x2_fifo: RTL and testbench

- Opposite end of the 2:1 valid-qualified mux path: takes one valid-qualified 2-bit stream and steers each word to one of two output channels, chosen by `selector`.
- Each output channel has its own FIFO with show-ahead reads and pop-driven draining.
- Back-pressure goes to the source through `readyIN`.
- Sits downstream of the mux datapath and feeds two independent consumers.

---
 rtl/demux1x2_fifo.sv | 132 +++++++++++++
 tb/tb_demux1x2_fifo.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/demux1x2_fifo.sv
`default_nettype none
// ============================================================================
// Module   : demux1x2_fifo
// Brief    : 1:2 valid-qualified demultiplexer. Each input word is steered by
//            `selector` into one of two show-ahead FIFOs, which are drained
//            independently by pop0/pop1. readyIN back-pressures the source
//            whenever the selected channel is full.
// Options  : DEMUX_ERR_EN - when defined, enables the sticky overflow and
//            underflow flags (errOvf/errUnf); otherwise both are tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module demux1x2_fifo #(
    parameter int DATA_W = 2,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              selector,
    input  logic [DATA_W-1:0] dataIn,
    input  logic              validIN,
    output logic              readyIN,
    input  logic              pop0,
    input  logic              pop1,
    output logic [DATA_W-1:0] dataOut0,
    output logic              validOUT0,
    output logic [DATA_W-1:0] dataOut1,
    output logic              validOUT1,
    output logic [PTR_W:0]    count0,
    output logic [PTR_W:0]    count1,
    output logic              errOvf,
    output logic              errUnf
);

    localparam logic [PTR_W:0] c_FULL  = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] c_EMPTY = '0;

    logic [PTR_W:0]    w_count [2];
    logic [DATA_W-1:0] w_head  [2];
    logic [1:0]        w_popReq;
    logic              w_ready;

    assign w_popReq = {pop1, pop0};

    // Ready looks only at the selected channel's occupancy; a pop in the same
    // cycle does not free a slot for the incoming word.
    assign w_ready = ((selector ? w_count[1] : w_count[0]) != c_FULL);
    assign readyIN = w_ready;

    genvar ch;
    generate
        for (ch = 0; ch < 2; ch++) begin : g_ch
            localparam logic c_SEL = (ch == 1);

            logic [DATA_W-1:0] r_mem [DEPTH];
            logic [PTR_W-1:0]  r_wrPtr;
            logic [PTR_W-1:0]  r_rdPtr;
            logic [PTR_W:0]    r_count;
            logic              w_push;
            logic              w_pop;

            assign w_push = validIN && w_ready && (selector == c_SEL);
            // A pop on an empty channel is simply dropped.
            assign w_pop  = w_popReq[ch] && (r_count != c_EMPTY);

            // Storage write; contents are deliberately left untouched by reset.
            always_ff @(posedge clk) begin
                if (!reset && w_push) begin
                    r_mem[r_wrPtr] <= dataIn;
                end
            end

            // Pointer and occupancy tracking; full/empty come from the count,
            // so pointers may wrap freely at DEPTH.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_wrPtr <= '0;
                    r_rdPtr <= '0;
                    r_count <= '0;
                end else begin
                    if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
                    if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
                    case ({w_push, w_pop})
                        2'b10:   r_count <= r_count + 1'b1;
                        2'b01:   r_count <= r_count - 1'b1;
                        default: r_count <= r_count;
                    endcase
                end
            end

            assign w_count[ch] = r_count;
            // Show-ahead: the head word is read straight out of the array.
            assign w_head[ch]  = r_mem[r_rdPtr];
        end
    endgenerate

    assign dataOut0  = w_head[0];
    assign dataOut1  = w_head[1];
    assign count0    = w_count[0];
    assign count1    = w_count[1];
    assign validOUT0 = (w_count[0] != c_EMPTY);
    assign validOUT1 = (w_count[1] != c_EMPTY);

`ifdef DEMUX_ERR_EN
    logic r_errOvf;
    logic r_errUnf;

    // Sticky protocol-error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_errOvf <= 1'b0;
            r_errUnf <= 1'b0;
        end else begin
            if (validIN && !w_ready) begin
                r_errOvf <= 1'b1;
            end
            if ((pop0 && (w_count[0] == c_EMPTY)) ||
                (pop1 && (w_count[1] == c_EMPTY))) begin
                r_errUnf <= 1'b1;
            end
        end
    end

    assign errOvf = r_errOvf;
    assign errUnf = r_errUnf;
`else
    assign errOvf = 1'b0;
    assign errUnf = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_demux1x2_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux1x2_fifo
// Brief    : Directed self-checking bench for demux1x2_fifo. Expected error
//            flag values follow whether DEMUX_ERR_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux1x2_fifo;

`ifdef DEMUX_ERR_EN
    localparam logic c_ERR = 1'b1;
`else
    localparam logic c_ERR = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       selector;
    logic [1:0] dataIn;
    logic       validIN;
    logic       readyIN;
    logic       pop0;
    logic       pop1;
    logic [1:0] dataOut0;
    logic       validOUT0;
    logic [1:0] dataOut1;
    logic       validOUT1;
    logic [2:0] count0;
    logic [2:0] count1;
    logic       errOvf;
    logic       errUnf;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    logic [1:0] model[$];
    logic [1:0] val;

    demux1x2_fifo #(.DATA_W(2), .DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .reset(reset), .selector(selector), .dataIn(dataIn),
        .validIN(validIN), .readyIN(readyIN), .pop0(pop0), .pop1(pop1),
        .dataOut0(dataOut0), .validOUT0(validOUT0),
        .dataOut1(dataOut1), .validOUT1(validOUT1),
        .count0(count0), .count1(count1), .errOvf(errOvf), .errUnf(errUnf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; selector = 1'b0; dataIn = 2'b00; validIN = 1'b0;
        pop0 = 1'b0; pop1 = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_count0", 8'(count0), 8'd0);
        check("rst_count1", 8'(count1), 8'd0);
        check("rst_valid0", 8'(validOUT0), 8'd0);
        check("rst_valid1", 8'(validOUT1), 8'd0);
        check("rst_ready",  8'(readyIN), 8'd1);
        check("rst_errOvf", 8'(errOvf), 8'd0);
        check("rst_errUnf", 8'(errUnf), 8'd0);

        // Single pushes to each channel.
        selector = 1'b0; dataIn = 2'b01; validIN = 1'b1;
        tick();
        selector = 1'b1; dataIn = 2'b10;
        check("p1_valid0", 8'(validOUT0), 8'd1);
        check("p1_data0",  8'(dataOut0), 8'h1);
        check("p1_count0", 8'(count0), 8'd1);
        tick();
        validIN = 1'b0;
        check("p1_valid1", 8'(validOUT1), 8'd1);
        check("p1_data1",  8'(dataOut1), 8'h2);
        check("p1_count1", 8'(count1), 8'd1);
        check("p1_count0_hold", 8'(count0), 8'd1);

        // Both pops together drain both channels.
        pop0 = 1'b1; pop1 = 1'b1;
        tick();
        pop0 = 1'b0; pop1 = 1'b0;
        check("dual_pop_count0", 8'(count0), 8'd0);
        check("dual_pop_count1", 8'(count1), 8'd0);

        // Fill channel 0 to DEPTH.
        selector = 1'b0; validIN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dataIn = 2'(i);
            tick();
        end
        validIN = 1'b0;
        #1;
        check("full_count0", 8'(count0), 8'd4);
        check("full_ready_sel0", 8'(readyIN), 8'd0);
        selector = 1'b1;
        #1;
        check("full_ready_sel1", 8'(readyIN), 8'd1);
        selector = 1'b0;
        check("full_errOvf_before", 8'(errOvf), 8'd0);

        // Fifth push is refused.
        dataIn = 2'b11; validIN = 1'b1;
        tick();
        validIN = 1'b0;
        check("ovf_count0", 8'(count0), 8'd4);
        check("ovf_head0", 8'(dataOut0), 8'h0);
        check("ovf_errOvf", 8'(errOvf), 8'(c_ERR));

        // Drain in order.
        pop0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_valid0", 8'(validOUT0), 8'd1);
            check("drain_data0", 8'(dataOut0), 8'(i));
            tick();
        end
        pop0 = 1'b0;
        check("drain_valid0_end", 8'(validOUT0), 8'd0);
        check("drain_count0_end", 8'(count0), 8'd0);
        check("drain_errUnf", 8'(errUnf), 8'd0);

        // Two words in, then simultaneous push/pop across the wrap point.
        model.delete();
        selector = 1'b0; validIN = 1'b1;
        dataIn = 2'b10; model.push_back(2'b10); tick();
        dataIn = 2'b01; model.push_back(2'b01); tick();
        check("pp_count0_start", 8'(count0), 8'd2);
        pop0 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            val = 2'(i + 3);
            dataIn = val;
            check("pp_head0", 8'(dataOut0), 8'(model[0]));
            tick();
            model.push_back(val);
            void'(model.pop_front());
            check("pp_count0", 8'(count0), 8'd2);
        end
        validIN = 1'b0;
        while (model.size() > 0) begin
            check("pp_tail_head0", 8'(dataOut0), 8'(model[0]));
            void'(model.pop_front());
            tick();
        end
        pop0 = 1'b0;
        check("pp_count0_end", 8'(count0), 8'd0);

        // Pop on empty channel 1.
        pop1 = 1'b1;
        tick();
        pop1 = 1'b0;
        check("unf_count1", 8'(count1), 8'd0);
        check("unf_valid1", 8'(validOUT1), 8'd0);
        check("unf_errUnf", 8'(errUnf), 8'(c_ERR));
        selector = 1'b1; dataIn = 2'b11; validIN = 1'b1;
        tick();
        validIN = 1'b0;
        check("unf_push_data1", 8'(dataOut1), 8'h3);
        check("unf_push_count1", 8'(count1), 8'd1);

        // Partly fill both channels, then reset with a push and pop pending.
        selector = 1'b0; validIN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dataIn = 2'(i + 1);
            tick();
        end
        selector = 1'b1; dataIn = 2'b00;
        tick();
        check("pre_rst_count0", 8'(count0), 8'd3);
        check("pre_rst_count1", 8'(count1), 8'd2);
        reset = 1'b1; selector = 1'b0; pop0 = 1'b1;
        tick();
        reset = 1'b0; validIN = 1'b0; pop0 = 1'b0;
        #1;
        check("mid_rst_count0", 8'(count0), 8'd0);
        check("mid_rst_count1", 8'(count1), 8'd0);
        check("mid_rst_valid0", 8'(validOUT0), 8'd0);
        check("mid_rst_valid1", 8'(validOUT1), 8'd0);
        check("mid_rst_ready",  8'(readyIN), 8'd1);
        check("mid_rst_errOvf", 8'(errOvf), 8'd0);
        check("mid_rst_errUnf", 8'(errUnf), 8'd0);

        // Fresh push after reset lands at the head of channel 0.
        selector = 1'b0; dataIn = 2'b10; validIN = 1'b1;
        tick();
        validIN = 1'b0;
        check("post_rst_data0", 8'(dataOut0), 8'h2);
        check("post_rst_count0", 8'(count0), 8'd1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, required finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
